// File: rtl/inst_prefetch_pkg.sv
// -----------------------------------------------------------------------------
// inst_prefetch_pkg
// Shared definitions for the instruction prefetch unit: the NOP filler word,
// the default boot address, the fetch FSM encoding and the queue entry layout.
// -----------------------------------------------------------------------------
package inst_prefetch_pkg;

  // RISC-V canonical NOP (addi x0, x0, 0), shown on inst_o when the queue is empty.
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    FETCH    = 2'd1,
    REDIRECT = 2'd2
  } pf_state_e;

  // One queue slot: the fetched word together with the address it came from.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
  } pf_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_prefetch_if.sv
// -----------------------------------------------------------------------------
// inst_prefetch_if
// Bundles the prefetcher's ROM port, redirect port and core-side instruction
// handshake.
//   master : the prefetcher (drives rom_req_o/rom_addr_o and the inst_* outputs)
//   slave  : the environment (ROM + core; drives rom_inst_i, flush_*, inst_ready_i)
// -----------------------------------------------------------------------------
interface inst_prefetch_if;

  logic        rom_req_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_inst_i;
  logic        flush_i;
  logic [31:0] flush_addr_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_ready_i;

  modport master (
    output rom_req_o, rom_addr_o, inst_valid_o, inst_o, inst_addr_o,
    input  rom_inst_i, flush_i, flush_addr_i, inst_ready_i
  );

  modport slave (
    input  rom_req_o, rom_addr_o, inst_valid_o, inst_o, inst_addr_o,
    output rom_inst_i, flush_i, flush_addr_i, inst_ready_i
  );

endinterface

// File: rtl/inst_prefetch_pf_fifo.sv
// -----------------------------------------------------------------------------
// pf_fifo
// DEPTH x 64-bit synchronous FIFO holding prefetched {addr, inst} entries.
// The head entry is read combinationally from storage.
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear_i      : empties the FIFO; wins over push_i/pop_i in the same cycle
//   push_i       : write push_data_i at the tail
//   pop_i        : drop the head entry (ignored when empty)
//   head_o       : current head entry (undefined contents when empty_o=1)
//   count_o      : number of valid entries, 0..DEPTH
//   full_o       : count_o == DEPTH
//   empty_o      : count_o == 0
// -----------------------------------------------------------------------------
module pf_fifo
  import inst_prefetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             push_i,
  input  pf_entry_t        push_data_i,
  input  logic             pop_i,
  output pf_entry_t        head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  pf_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    do_push  = push_i && !clear_i;
    do_pop   = pop_i && !clear_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap on their own.
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; entries are only visible through
  // count_q, which is reset, so stale contents can never be observed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

  // The producer's credit scheme must make overflow impossible.
  no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && !clear_i && full_o));

endmodule

// File: rtl/inst_prefetch.sv
// -----------------------------------------------------------------------------
// inst_prefetch
// Instruction prefetch unit: fetches sequential words from a one-cycle-latency
// instruction ROM into a small queue and hands them to the core with a
// valid/ready handshake. A flush redirects fetching to a new target and
// discards everything queued or in flight.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : inst_prefetch_if.master (ROM request/response, flush, inst handshake)
// -----------------------------------------------------------------------------
module inst_prefetch
  import inst_prefetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  inst_prefetch_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int CRD_W = CNT_W + 1;

  pf_state_e        state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             inflight_q, inflight_d;

  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty;
  pf_entry_t        fifo_head;
  pf_entry_t        fifo_wdata;
  logic [CRD_W-1:0] credit_used;
  logic             rom_req, fifo_push, fifo_pop;

  always_comb begin
    // A slot is reserved for every request still in flight, so the queue can
    // never be asked to accept a response it has no room for.
    credit_used = {1'b0, fifo_count} + CRD_W'(inflight_q);
    // The request is not registered: a flush in this very cycle must suppress it.
    rom_req     = (state_q == FETCH) && !bus.flush_i && !fifo_full
                  && (credit_used < CRD_W'(DEPTH));
    // Flush discards the response arriving this cycle and beats a pop.
    fifo_push   = inflight_q && !bus.flush_i;
    fifo_pop    = !fifo_empty && bus.inst_ready_i && !bus.flush_i;
    // pc_q already moved on by 4 when the request was issued.
    fifo_wdata  = '{addr: pc_q - 32'd4, inst: bus.rom_inst_i};

    state_d    = state_q;
    pc_d       = pc_q;
    inflight_d = rom_req;
    if (bus.flush_i) begin
      state_d = REDIRECT;
      pc_d    = word_align(bus.flush_addr_i);
    end else begin
      // BOOT and REDIRECT each last exactly one cycle.
      state_d = FETCH;
      if (rom_req) pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
    end
  end

  pf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst),
    .clear_i     (bus.flush_i),
    .push_i      (fifo_push),
    .push_data_i (fifo_wdata),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign bus.rom_req_o    = rom_req;
  assign bus.rom_addr_o   = pc_q;
  assign bus.inst_valid_o = !fifo_empty;
  assign bus.inst_o       = fifo_empty ? NOP_INST : fifo_head.inst;
  assign bus.inst_addr_o  = fifo_empty ? 32'h0 : fifo_head.addr;

endmodule

// File: doc/inst_prefetch.md
INST_PREFETCH -- requirements
Module: inst_prefetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, 2..8).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rom_req_o  output  1  fetch request to instruction ROM this cycle.
REQ-006 SHALL have port rom_addr_o  output  32  byte address of requested word.
REQ-007 SHALL have port rom_inst_i  input  32  ROM data, valid exactly one cycle after rom_req_o.
REQ-008 SHALL have port flush_i  input  1  redirect pulse from core (jump/branch taken).
REQ-009 SHALL have port flush_addr_i  input  32  redirect target, sampled when flush_i=1.
REQ-010 SHALL have port inst_valid_o  output  1  queue head valid.
REQ-011 SHALL have port inst_o  output  32  head instruction; 32'h0000_0013 (NOP) when invalid.
REQ-012 SHALL have port inst_addr_o  output  32  head instruction address; 0 when invalid.
REQ-013 SHALL have port inst_ready_i  input  1  core consumes head when inst_valid_o and inst_ready_i both 1.

Function
REQ-014 SHALL implement FSM states BOOT, FETCH, REDIRECT; BOOT after reset, BOOT->FETCH unconditionally next cycle.
REQ-015 SHALL keep a fetch PC register; rom_addr_o SHALL equal fetch PC every cycle.
REQ-016 SHALL assert rom_req_o in FETCH only when occupancy + inflight < DEPTH and flush_i=0; never in BOOT or REDIRECT.
REQ-017 SHALL increment fetch PC by 4 (modulo 2^32, wrap 32'hFFFF_FFFC->0) on each cycle rom_req_o=1.
REQ-018 SHALL set inflight=1 the cycle after a request and write {fetch address, rom_inst_i} into queue tail in that cycle unless discarded.
REQ-019 SHALL present queue head on inst_o/inst_addr_o combinationally from storage; write-to-valid latency is one cycle (min ROM-request-to-inst_valid_o latency = 2 cycles).
REQ-020 SHALL pop head on handshake; push and pop in the same cycle leave occupancy unchanged.
REQ-021 SHALL never push when full; REQ-016 credit rule guarantees this, and an attempted overflow SHALL be a verification error.
REQ-022 SHALL, on flush_i=1 in any state: empty queue, discard any response arriving that same cycle, set fetch PC to {flush_addr_i[31:2],2'b00}, enter REDIRECT.
REQ-023 SHALL move REDIRECT->FETCH next cycle; first request to target issued in that FETCH cycle.
REQ-024 SHALL give flush_i priority over a simultaneous pop, push, or request; inst_valid_o SHALL be 0 the cycle after flush.
REQ-025 SHALL, when a flush coincides with inflight=1 from the previous cycle, drop that response (never enters queue).
REQ-026 SHALL hold inst_o/inst_addr_o stable while inst_valid_o=1 and inst_ready_i=0.

Reset
REQ-027 SHALL, on rst=0, immediately: state BOOT, fetch PC RESET_PC, occupancy 0, inflight 0, rom_req_o 0, inst_valid_o 0, inst_o NOP, inst_addr_o 0.
REQ-028 SHALL, on reset assertion mid-operation, drop all queued and inflight instructions; no response is captured after release.
REQ-029 SHALL issue first request (addr RESET_PC) in the second cycle after rst release.

Structure
REQ-030 SHALL place NOP constant, default RESET_PC, and FSM state encodings in the shared core package.
REQ-031 SHALL instantiate one sub-module pf_fifo (DEPTH x 64-bit synchronous FIFO with clear, count, full, empty).
REQ-032 SHALL keep inflight flag, fetch PC, and FSM in the top level; no other sub-modules.

Verification
REQ-033 Reset release, inst_ready_i=1, ROM returns addr-as-data -> rom_addr_o 0,4,8,... ; inst_valid_o first high 3 cycles after release with inst_addr_o=0.
REQ-034 inst_ready_i=0 from reset, DEPTH=4 -> exactly 4 requests (0..C), rom_req_o then stays 0; head stays addr 0, inst_o stable.
REQ-035 flush_i=1 with flush_addr_i=32'h0000_0102 while inflight=1 and queue holding 2 -> queue empty next cycle, inflight data dropped, next request addr 32'h0000_0100.
REQ-036 Queue full, pop and flush same cycle -> flush wins; inst_valid_o=0 next cycle, no stale instruction ever delivered.
REQ-037 RESET_PC=32'hFFFF_FFF8, inst_ready_i=1 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000 in order.
REQ-038 rst asserted with queue half full and inflight=1 -> all outputs at reset values same cycle; after release first delivered inst_addr_o=RESET_PC.
